// File: rtl/router_pkg.sv
// Shared flit encoding, crossbar port indices and FSM state type for the mesh router.
package router_pkg;

    localparam logic [2:0] FLIT_HEAD   = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;
    localparam logic [2:0] FLIT_SINGLE = 3'b011;

    localparam int PORT_L    = 0;
    localparam int PORT_N    = 1;
    localparam int PORT_S    = 2;
    localparam int PORT_E    = 3;
    localparam int PORT_W    = 4;
    localparam int NUM_PORTS = 5;

    typedef struct packed {
        logic [2:0] flit_type;
        logic [3:0] dest;
        logic [8:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic logic is_head(input logic [2:0] t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic is_tail(input logic [2:0] t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/router_flit_fifo.sv
// First-word-fall-through flit buffer; push is ignored when full, pop is ignored when empty.
module router_flit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] front,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign front   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_local_input_port.sv
// Local injection port: buffers NI flits, XY-routes each packet and streams it to the crossbar.
// Optional PORT_STATS_EN adds pkt_count / drop_count statistics outputs.
module router_local_input_port
    import router_pkg::*;
#(
    parameter int         DEPTH       = 4,
    parameter logic [3:0] ROUTER_ADDR = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_req,
    input  logic [15:0]          in_data,
    output logic                 in_bussy,
    output logic [NUM_PORTS-1:0] out_req,
    input  logic                 out_grant,
    input  logic                 out_bussy,
    output logic                 out_valid,
    output logic [15:0]          out_data,
    output logic                 out_release,
    output logic                 drop_flit,
    output logic [1:0]           fsm_state
`ifdef PORT_STATS_EN
    ,
    output logic [15:0]          pkt_count,
    output logic [7:0]           drop_count
`endif
);

    // Handshakes: a flit enters on a rising edge with in_req=1 and in_bussy=0; a flit
    // leaves on an edge in SEND with the buffer non-empty and out_bussy=0, and is shown
    // on out_data/out_valid for the following cycle.

    state_t                 state;
    state_t                 state_d;
    flit_t                  front;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   send_pop;
    logic                   route_load;
    logic [NUM_PORTS-1:0]   route_d;
    logic [NUM_PORTS-1:0]   route_q;

    assign in_bussy  = fifo_full;
    assign fsm_state = state;

    router_flit_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_req),
        .push_data (in_data),
        .pop       (fifo_pop),
        .front     (front),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // XY routing: resolve x first, then y; equal address ejects locally.
    always_comb begin
        route_d = '0;
        if (front.dest[1:0] > ROUTER_ADDR[1:0]) begin
            route_d[PORT_E] = 1'b1;
        end else if (front.dest[1:0] < ROUTER_ADDR[1:0]) begin
            route_d[PORT_W] = 1'b1;
        end else if (front.dest[3:2] > ROUTER_ADDR[3:2]) begin
            route_d[PORT_S] = 1'b1;
        end else if (front.dest[3:2] < ROUTER_ADDR[3:2]) begin
            route_d[PORT_N] = 1'b1;
        end else begin
            route_d[PORT_L] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state;
        fifo_pop   = 1'b0;
        send_pop   = 1'b0;
        drop_flit  = 1'b0;
        route_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (is_head(front.flit_type)) begin
                        route_load = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        fifo_pop  = 1'b1;
                        drop_flit = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (out_grant) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!fifo_empty && !out_bussy) begin
                    fifo_pop = 1'b1;
                    send_pop = 1'b1;
                    if (is_tail(front.flit_type)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_req = ((state == ST_REQ) || (state == ST_SEND)) ? route_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            route_q     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_release <= 1'b0;
        end else begin
            state       <= state_d;
            out_valid   <= send_pop;
            out_release <= send_pop && is_tail(front.flit_type);
            if (route_load) begin
                route_q <= route_d;
            end
            if (send_pop) begin
                out_data <= front;
            end
        end
    end

`ifdef PORT_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (out_release) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (drop_flit) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_router_local_input_port.sv
// Directed bench for router_local_input_port (ROUTER_ADDR=5, DEPTH=4).
module tb_router_local_input_port;

    localparam logic [2:0] T_HEAD   = 3'b001;
    localparam logic [2:0] T_BODY   = 3'b010;
    localparam logic [2:0] T_TAIL   = 3'b100;
    localparam logic [2:0] T_SINGLE = 3'b011;

    logic        clk;
    logic        rst;
    logic        in_req;
    logic [15:0] in_data;
    logic        in_bussy;
    logic [4:0]  out_req;
    logic        out_grant;
    logic        out_bussy;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_release;
    logic        drop_flit;
    logic [1:0]  fsm_state;
`ifdef PORT_STATS_EN
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;
`endif

    int errors = 0;
    int checks = 0;
    int n_rel;
    int rel_bad;
    int first_valid;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    router_local_input_port #(
        .DEPTH       (4),
        .ROUTER_ADDR (4'd5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_req      (in_req),
        .in_data     (in_data),
        .in_bussy    (in_bussy),
        .out_req     (out_req),
        .out_grant   (out_grant),
        .out_bussy   (out_bussy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_release (out_release),
        .drop_flit   (drop_flit),
        .fsm_state   (fsm_state)
`ifdef PORT_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .drop_count  (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] t, input logic [3:0] d, input logic [8:0] p);
        return {t, d, p};
    endfunction

    // Tasks start and end just after a rising edge; outputs are sampled on falling edges.
    task automatic push(input logic [15:0] d);
        int n;
        n = 0;
        in_req  = 1'b1;
        in_data = d;
        @(negedge clk);
        while (in_bussy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_bussy) begin
            errors++;
            $display("FAIL push_timeout: in_bussy=%b required 0 within 50 cycles", in_bussy);
        end
        @(posedge clk);
        #1;
        in_req = 1'b0;
    endtask

    task automatic drain(input int budget, input bit toggle);
        bit done;
        done        = 1'b0;
        n_rel       = 0;
        rel_bad     = 0;
        first_valid = -1;
        for (int i = 0; i < budget && !done; i++) begin
            if (toggle) out_bussy = (i % 2 == 0);
            @(negedge clk);
            if (out_valid) begin
                got_q.push_back(out_data);
                if (first_valid < 0) first_valid = i;
            end
            if (out_release) begin
                n_rel++;
                if (!out_valid) rel_bad++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        out_bussy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_req = 1'b0; in_data = '0; out_grant = 1'b0; out_bussy = 1'b0;
        #2;
        checks++; if (in_bussy !== 1'b0) begin errors++; $display("FAIL rst_in_bussy: got %b required 0", in_bussy); end
        checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL rst_out_req: got %b required 00000", out_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h required 0000", out_data); end
        checks++; if (out_release !== 1'b0) begin errors++; $display("FAIL rst_out_release: got %b required 0", out_release); end
        checks++; if (drop_flit !== 1'b0) begin errors++; $display("FAIL rst_drop_flit: got %b required 0", drop_flit); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", fsm_state); end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_packet(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d flits required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_flit%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (n_rel != 1 || rel_bad != 0) begin
            errors++;
            $display("FAIL %s_release: got %0d pulses (%0d without valid) required 1 (0)", name, n_rel, rel_bad);
        end
    endtask

    // Router (1,1) to dest 7 (3,1): east.
    task automatic test_xy_east();
        exp_q = '{mk(T_HEAD, 4'd7, 9'h011), mk(T_BODY, 4'd7, 9'h022), mk(T_TAIL, 4'd7, 9'h033)};
        got_q.delete();
        out_grant = 1'b0;
        push(exp_q[0]);
        @(negedge clk);
        checks++; if (out_req !== 5'b00000) begin errors++; $display("FAIL east_req_lat0: got %b required 00000", out_req); end
        @(negedge clk);
        checks++; if (out_req !== 5'b01000) begin errors++; $display("FAIL east_req_lat1: got %b required 01000", out_req); end
        @(posedge clk);
        #1;
        push(exp_q[1]);
        push(exp_q[2]);
        out_grant = 1'b1;
        drain(20, 1'b0);
        check_packet("east");
        checks++; if (first_valid != 2) begin errors++; $display("FAIL east_grant_latency: got %0d required 2", first_valid); end
        out_grant = 1'b0;
        @(negedge clk);
        checks++; if (out_req !== 5'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL east_after: out_req=%b out_valid=%b required 00000 0", out_req, out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_local();
        exp_q = '{mk(T_SINGLE, 4'd5, 9'h155)};
        got_q.delete();
        push(exp_q[0]);
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_req !== 5'b00001) begin errors++; $display("FAIL local_req: got %b required 00001", out_req); end
        @(posedge clk);
        #1;
        out_grant = 1'b1;
        drain(20, 1'b0);
        check_packet("local");
        out_grant = 1'b0;
    endtask

    // Dest 4 (0,1): west. Buffer fills while the grant is withheld.
    task automatic test_fill();
        int held;
        bit freed;
        logic [15:0] s2;
        held  = 0;
        freed = 1'b0;
        s2    = mk(T_SINGLE, 4'd5, 9'h0aa);
        exp_q = '{mk(T_HEAD, 4'd4, 9'h101), mk(T_BODY, 4'd4, 9'h102), mk(T_BODY, 4'd4, 9'h103), mk(T_TAIL, 4'd4, 9'h104)};
        got_q.delete();
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        @(negedge clk);
        checks++; if (in_bussy !== 1'b1) begin errors++; $display("FAIL fill_bussy: got %b required 1", in_bussy); end
        checks++; if (out_req !== 5'b10000) begin errors++; $display("FAIL fill_req_west: got %b required 10000", out_req); end
        in_req  = 1'b1;
        in_data = s2;
        repeat (3) begin
            @(negedge clk);
            if (in_bussy) held++;
        end
        checks++; if (held != 3) begin errors++; $display("FAIL fill_held_off: got %0d busy cycles required 3", held); end
        @(posedge clk);
        #1;
        out_grant = 1'b1;
        for (int i = 0; i < 20 && !freed; i++) begin
            @(negedge clk);
            if (out_valid) got_q.push_back(out_data);
            if (!in_bussy) freed = 1'b1;
            @(posedge clk);
            #1;
        end
        in_req = 1'b0;
        checks++; if (!freed) begin errors++; $display("FAIL fill_free: in_bussy stuck at 1 required 0 after grant"); end
        drain(20, 1'b0);
        check_packet("fill");
        exp_q = '{s2};
        got_q.delete();
        drain(20, 1'b0);
        check_packet("fill_next");
        out_grant = 1'b0;
    endtask

    task automatic test_drop();
        int drops;
        int reqs;
        drops = 0;
        reqs  = 0;
        push(mk(T_BODY, 4'd3, 9'h1ff));
        repeat (4) begin
            @(negedge clk);
            if (drop_flit) drops++;
            if (out_req !== 5'b0) reqs++;
            @(posedge clk);
            #1;
        end
        checks++; if (drops != 1) begin errors++; $display("FAIL drop_pulse: got %0d pulses required 1", drops); end
        checks++; if (reqs != 0) begin errors++; $display("FAIL drop_no_req: got %0d req cycles required 0", reqs); end
        exp_q = '{mk(T_SINGLE, 4'd6, 9'h066)};
        got_q.delete();
        push(exp_q[0]);
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_req !== 5'b01000) begin errors++; $display("FAIL drop_next_req: got %b required 01000", out_req); end
        @(posedge clk);
        #1;
        out_grant = 1'b1;
        drain(20, 1'b0);
        check_packet("drop_next");
        out_grant = 1'b0;
    endtask

    // Dest 1 (1,0): north, with downstream backpressure toggling.
    task automatic test_backpressure();
        exp_q = '{mk(T_HEAD, 4'd1, 9'h0f1), mk(T_BODY, 4'd1, 9'h0f2), mk(T_BODY, 4'd1, 9'h0f3), mk(T_TAIL, 4'd1, 9'h0f4)};
        got_q.delete();
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        @(negedge clk);
        checks++; if (out_req !== 5'b00010) begin errors++; $display("FAIL bp_req_north: got %b required 00010", out_req); end
        @(posedge clk);
        #1;
        out_grant = 1'b1;
        drain(40, 1'b1);
        check_packet("bp");
        out_grant = 1'b0;
    endtask

    // Dest 9 (1,2): south; reset lands mid-packet.
    task automatic test_reset_mid_packet();
        bit seen;
        int stray;
        seen  = 1'b0;
        stray = 0;
`ifdef PORT_STATS_EN
        checks++; if (pkt_count !== 16'd6) begin errors++; $display("FAIL stats_pkt: got %0d required 6", pkt_count); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL stats_drop: got %0d required 1", drop_count); end
`endif
        push(mk(T_HEAD, 4'd9, 9'h011));
        push(mk(T_BODY, 4'd9, 9'h012));
        push(mk(T_BODY, 4'd9, 9'h013));
        checks++; if (out_req !== 5'b00100) begin errors++; $display("FAIL rstmid_req_south: got %b required 00100", out_req); end
        out_grant = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_send: out_valid never 1 within 20 cycles"); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL rstmid_out_req: got %b required 00000", out_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rstmid_out_data: got %h required 0000", out_data); end
        checks++; if (out_release !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b required 0", out_release); end
        checks++; if (in_bussy !== 1'b0 || drop_flit !== 1'b0) begin errors++; $display("FAIL rstmid_misc: in_bussy=%b drop_flit=%b required 0 0", in_bussy, drop_flit); end
`ifdef PORT_STATS_EN
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rstmid_pkt_count: got %0d required 0", pkt_count); end
`endif
        out_grant = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_req !== 5'b0 || drop_flit || out_valid || in_bussy) stray++;
            @(posedge clk);
            #1;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rstmid_fifo_empty: got %0d active cycles required 0", stray); end
    endtask

    initial begin
        test_reset();
        test_xy_east();
        test_single_local();
        test_fill();
        test_drop();
        test_backpressure();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
